// File: rtl/cdb_arb_pkg.sv
// Shared definitions for the common data bus: requester indices, default
// sizes, the consumer-side bus bundle and the round-robin pointer helper.
package cdb_arb_pkg;

    localparam int CDB_N_REQ  = 3;
    localparam int CDB_SRC_W  = 2;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU = 2'd0;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_MDU = 2'd1;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_LSU = 2'd2;

    // Bundle seen by the ROB, register file and reservation-station wakeup.
    typedef struct packed {
        logic                  vld;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_bus_t;

    // Round-robin pointer advance: the slot after the winner, wrapping to 0.
    function automatic int rr_next(input int win, input int n);
        int nxt;
        if (win >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = win + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cdb_arb_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or above
// the pointer, wrapping to index 0. Also used for reservation-station issue.
module rr_arb #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_win,
    output logic          o_any
);

    logic w_hit;

    // Two passes: first the slots from ptr upward, then the wrapped slots from 0.
    always_comb begin
        o_grant = '0;
        o_win   = '0;
        o_any   = 1'b0;
        w_hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_hit      = i_en && !o_any && i_req[i] && (i >= int'(i_ptr));
            o_grant[i] = o_grant[i] | w_hit;
            o_win      = w_hit ? PW'(i) : o_win;
            o_any      = o_any | w_hit;
        end
        for (int i = 0; i < N; i++) begin
            w_hit      = i_en && !o_any && i_req[i];
            o_grant[i] = o_grant[i] | w_hit;
            o_win      = w_hit ? PW'(i) : o_win;
            o_any      = o_any | w_hit;
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// Common data bus arbiter: picks one of ALU/MDU/LSU per cycle in round-robin
// order and registers the winner's tag/data onto the broadcast bus.
// A stalled, occupied bus register blocks new grants; flush empties it.
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter  int TAG_W  = CDB_TAG_W,
    parameter  int DATA_W = CDB_DATA_W,
    parameter  int N_REQ  = CDB_N_REQ,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    cdb_stall,
    input  logic [N_REQ-1:0]        req_vld,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_rdy,
    output logic                    cdb_vld,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src
);

    logic [SRC_W-1:0]  r_ptr;
    logic              r_cdb_vld;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [SRC_W-1:0]  r_cdb_src;

    logic              w_hold;
    logic              w_ge;
    logic [N_REQ-1:0]  w_grant;
    logic [SRC_W-1:0]  w_win;
    logic              w_any;
    logic [TAG_W-1:0]  w_win_tag;
    logic [DATA_W-1:0] w_win_data;

    // Bus register is occupied and a consumer refuses it: nothing may move.
    assign w_hold = cdb_stall & r_cdb_vld;
    // Grants are suppressed during reset so req_rdy reads 0 while rst is high.
    assign w_ge   = ~rst & ~flush & ~w_hold;

    rr_arb #(
        .N (N_REQ)
    ) u_rr_arb (
        .i_req   (req_vld),
        .i_ptr   (r_ptr),
        .i_en    (w_ge),
        .o_grant (w_grant),
        .o_win   (w_win),
        .o_any   (w_any)
    );

    // One-hot AND-OR mux of the winning requester's tag and data.
    always_comb begin
        w_win_tag  = '0;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win_tag  = w_win_tag  | ({TAG_W{w_grant[i]}}  & req_tag[i*TAG_W +: TAG_W]);
            w_win_data = w_win_data | ({DATA_W{w_grant[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Round-robin pointer and broadcast register: load on grant, drain when
    // unstalled, hold while stalled, cleared by flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cdb_vld  <= 1'b0;
            r_cdb_tag  <= '0;
            r_cdb_data <= '0;
            r_cdb_src  <= '0;
        end else if (flush) begin
            r_ptr      <= '0;
            r_cdb_vld  <= 1'b0;
        end else if (w_any) begin
            r_ptr      <= SRC_W'(rr_next(int'(w_win), N_REQ));
            r_cdb_vld  <= 1'b1;
            r_cdb_tag  <= w_win_tag;
            r_cdb_data <= w_win_data;
            r_cdb_src  <= w_win;
        end else if (!w_hold) begin
            r_cdb_vld  <= 1'b0;
        end else begin
            r_cdb_vld  <= r_cdb_vld;
        end
    end

    assign req_rdy  = w_grant;
    assign cdb_vld  = r_cdb_vld;
    assign cdb_tag  = r_cdb_tag;
    assign cdb_data = r_cdb_data;
    assign cdb_src  = r_cdb_src;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed, table-driven bench for cdb_arb plus a hand-written async-reset case.
module tb_cdb_arb;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        cdb_stall;
    logic [2:0]  req_vld;
    logic [11:0] req_tag;
    logic [95:0] req_data;
    logic [2:0]  req_rdy;
    logic        cdb_vld;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arb dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cdb_stall (cdb_stall),
        .req_vld   (req_vld),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .cdb_vld   (cdb_vld),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        stall;
        logic [2:0]  vld;
        logic [11:0] tags;     // {t2, t1, t0}
        logic [2:0]  exp_rdy;  // grant expected this cycle
        logic        exp_vld;  // bus register as seen this cycle
        logic [3:0]  exp_tag;
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        logic [1:0]  exp_ptr;  // pointer as seen this cycle
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic logic [31:0] data_of(input int idx, input logic [3:0] tag);
        logic [31:0] d;
        if (idx == 0 && tag == 4'h5) d = 32'hDEAD_BEEF;
        else                         d = {16'hCAFE, 8'(idx), 4'h0, tag};
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic s, input logic [2:0] v, input logic [11:0] t);
        flush     = f;
        cdb_stall = s;
        req_vld   = v;
        req_tag   = t;
        req_data  = {data_of(2, t[11:8]), data_of(1, t[7:4]), data_of(0, t[3:0])};
    endtask

    initial begin
        //          flush stall vld     tags     rdy     vld  tag   data          src   ptr
        vecs[0]  = '{1'b0, 1'b0, 3'b001, 12'h005, 3'b001, 1'b0, 4'h0, 32'h0,        2'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 3'b000, 12'h000, 3'b000, 1'b1, 4'h5, 32'hDEAD_BEEF, 2'd0, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 3'b100, 12'h700, 3'b100, 1'b0, 4'h0, 32'h0,        2'd0, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 3'b111, 12'h321, 3'b001, 1'b1, 4'h7, 32'hCAFE_0207, 2'd2, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 3'b111, 12'h328, 3'b010, 1'b1, 4'h1, 32'hCAFE_0001, 2'd0, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 3'b111, 12'h398, 3'b100, 1'b1, 4'h2, 32'hCAFE_0102, 2'd1, 2'd2};
        vecs[6]  = '{1'b0, 1'b0, 3'b111, 12'hA98, 3'b001, 1'b1, 4'h3, 32'hCAFE_0203, 2'd2, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 3'b000, 12'h000, 3'b000, 1'b1, 4'h8, 32'hCAFE_0008, 2'd0, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 3'b010, 12'h030, 3'b010, 1'b0, 4'h0, 32'h0,        2'd0, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 12'h040, 3'b000, 1'b1, 4'h3, 32'hCAFE_0103, 2'd1, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 12'h040, 3'b000, 1'b1, 4'h3, 32'hCAFE_0103, 2'd1, 2'd2};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 12'h040, 3'b000, 1'b1, 4'h3, 32'hCAFE_0103, 2'd1, 2'd2};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 12'h040, 3'b010, 1'b1, 4'h3, 32'hCAFE_0103, 2'd1, 2'd2};
        vecs[13] = '{1'b0, 1'b0, 3'b000, 12'h000, 3'b000, 1'b1, 4'h4, 32'hCAFE_0104, 2'd1, 2'd2};
        vecs[14] = '{1'b0, 1'b1, 3'b100, 12'h500, 3'b100, 1'b0, 4'h0, 32'h0,        2'd0, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 3'b100, 12'h600, 3'b100, 1'b1, 4'h5, 32'hCAFE_0205, 2'd2, 2'd0};
        vecs[16] = '{1'b0, 1'b0, 3'b000, 12'h000, 3'b000, 1'b1, 4'h6, 32'hCAFE_0206, 2'd2, 2'd0};
        vecs[17] = '{1'b0, 1'b0, 3'b001, 12'h002, 3'b001, 1'b0, 4'h0, 32'h0,        2'd0, 2'd0};
        vecs[18] = '{1'b0, 1'b1, 3'b010, 12'h070, 3'b000, 1'b1, 4'h2, 32'hCAFE_0002, 2'd0, 2'd1};
        vecs[19] = '{1'b1, 1'b1, 3'b111, 12'h371, 3'b000, 1'b1, 4'h2, 32'hCAFE_0002, 2'd0, 2'd1};
        vecs[20] = '{1'b0, 1'b0, 3'b111, 12'h371, 3'b001, 1'b0, 4'h0, 32'h0,        2'd0, 2'd0};
        vecs[21] = '{1'b0, 1'b0, 3'b110, 12'h370, 3'b010, 1'b1, 4'h1, 32'hCAFE_0001, 2'd0, 2'd1};
        vecs[22] = '{1'b0, 1'b0, 3'b100, 12'h300, 3'b100, 1'b1, 4'h7, 32'hCAFE_0107, 2'd1, 2'd2};
        vecs[23] = '{1'b0, 1'b0, 3'b000, 12'h000, 3'b000, 1'b1, 4'h3, 32'hCAFE_0203, 2'd2, 2'd0};

        // Reset with all requesters asserted: no grant may leak out.
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b111, 12'h123);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rdy",  32'(req_rdy),  32'h0);
        chk("reset vld",  32'(cdb_vld),  32'h0);
        chk("reset tag",  32'(cdb_tag),  32'h0);
        chk("reset data", cdb_data,      32'h0);
        chk("reset src",  32'(cdb_src),  32'h0);
        chk("reset ptr",  32'(dut.r_ptr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < NV; r++) begin
            drive(vecs[r].flush, vecs[r].stall, vecs[r].vld, vecs[r].tags);
            @(negedge clk);
            chk($sformatf("row%0d rdy", r), 32'(req_rdy), 32'(vecs[r].exp_rdy));
            chk($sformatf("row%0d vld", r), 32'(cdb_vld), 32'(vecs[r].exp_vld));
            chk($sformatf("row%0d ptr", r), 32'(dut.r_ptr), 32'(vecs[r].exp_ptr));
            if (vecs[r].exp_vld) begin
                chk($sformatf("row%0d tag", r),  32'(cdb_tag), 32'(vecs[r].exp_tag));
                chk($sformatf("row%0d data", r), cdb_data,     vecs[r].exp_data);
                chk($sformatf("row%0d src", r),  32'(cdb_src), 32'(vecs[r].exp_src));
            end
            @(posedge clk);
            #1;
        end

        // Async reset while a broadcast is on the bus.
        drive(1'b0, 1'b0, 3'b010, 12'h090);
        @(negedge clk);
        chk("arst pre rdy", 32'(req_rdy), 32'h2);
        @(posedge clk);
        #1;
        chk("arst pre vld", 32'(cdb_vld), 32'h1);
        chk("arst pre tag", 32'(cdb_tag), 32'h9);
        drive(1'b0, 1'b0, 3'b111, 12'h321);
        #1;
        rst = 1'b1;
        #1;
        chk("arst vld drop", 32'(cdb_vld),   32'h0);
        chk("arst rdy",      32'(req_rdy),   32'h0);
        chk("arst tag",      32'(cdb_tag),   32'h0);
        chk("arst ptr",      32'(dut.r_ptr), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst rdy", 32'(req_rdy), 32'h1);
        @(posedge clk);
        #1;
        chk("post-rst vld",  32'(cdb_vld),  32'h1);
        chk("post-rst src",  32'(cdb_src),  32'h0);
        chk("post-rst data", cdb_data,      32'hCAFE_0001);
        drive(1'b0, 1'b0, 3'b000, 12'h000);
        @(posedge clk);
        #1;
        chk("post-rst drain", 32'(cdb_vld), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
